countdown_sprite_ctrl: RTL and testbench

- Upstream driver for the 32x32 one-bit digit sprite ROMs (frameRAM_one/two/three family).
- Runs a 3-2-1 countdown timed in video frames.
- Converts the current VGA pixel (DrawX, DrawY) into a ROM read_address and produces a pixel-aligned sprite_on flag and digit select for the colour mapper.
- Compensates for the ROMs' one-cycle registered read latency.

---
 rtl/countdown_sprite_ctrl.sv | 130 +++++++++++++
 tb/tb_countdown_sprite_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/countdown_sprite_ctrl.sv
// 3-2-1 frame-timed countdown driving the 32x32 digit sprite ROMs: pixel->ROM address plus ROM-aligned sprite_on/digit_sel.
// Optional macro SPRITE_SCALE2X_EN draws the sprite at double size from the same ROM.
module countdown_sprite_ctrl #(
    parameter int FRAMES_PER_DIGIT = 60,
    parameter int SPRITE_DIM       = 32
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        start,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [9:0]  pos_x,
    input  logic [9:0]  pos_y,
    output logic [18:0] read_address,
    output logic        sprite_on,
    output logic [1:0]  digit_sel,
    output logic        busy,
    output logic        done
);

    localparam int ADDR_SHIFT = $clog2(SPRITE_DIM);
`ifdef SPRITE_SCALE2X_EN
    localparam int BOX      = 2 * SPRITE_DIM;
    localparam int SCALE_SH = 1;
`else
    localparam int BOX      = SPRITE_DIM;
    localparam int SCALE_SH = 0;
`endif

    typedef enum logic [2:0] {IDLE, SHOW3, SHOW2, SHOW1, FIN} state_t;

    state_t      state;
    logic        frame_q;
    logic        frame_tick;
    logic        last_frame;
    logic [7:0]  frame_cnt;
    logic [9:0]  px;
    logic [9:0]  py;
    logic [10:0] x_end;
    logic [10:0] y_end;
    logic [10:0] dx;
    logic [10:0] dy;
    logic [10:0] dx_s;
    logic [10:0] dy_s;
    logic        in_box;
    logic [1:0]  cur_digit;

    assign frame_tick = frame_clk & ~frame_q;
    assign last_frame = (frame_cnt == 8'(FRAMES_PER_DIGIT - 1));

    // 11-bit box limits so a sprite near column/row 1023 never wraps to 0
    assign x_end  = {1'b0, px} + 11'(BOX);
    assign y_end  = {1'b0, py} + 11'(BOX);
    assign in_box = ({1'b0, DrawX} >= {1'b0, px}) && ({1'b0, DrawX} < x_end) &&
                    ({1'b0, DrawY} >= {1'b0, py}) && ({1'b0, DrawY} < y_end);
    assign dx     = {1'b0, DrawX} - {1'b0, px};
    assign dy     = {1'b0, DrawY} - {1'b0, py};
    assign dx_s   = dx >> SCALE_SH;
    assign dy_s   = dy >> SCALE_SH;

    assign read_address = in_box ? ((19'(dy_s) << ADDR_SHIFT) | 19'(dx_s)) : 19'd0;

    always_comb begin
        cur_digit = 2'd0;
        case (state)
            SHOW3:   cur_digit = 2'd3;
            SHOW2:   cur_digit = 2'd2;
            SHOW1:   cur_digit = 2'd1;
            default: cur_digit = 2'd0;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            frame_q   <= 1'b0;
            frame_cnt <= 8'd0;
            px        <= 10'd0;
            py        <= 10'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sprite_on <= 1'b0;
            digit_sel <= 2'd0;
        end else begin
            frame_q   <= frame_clk;
            done      <= 1'b0;
            // Registered to line up with the ROM's one-cycle data_Out
            sprite_on <= in_box && busy;
            digit_sel <= (in_box && busy) ? cur_digit : 2'd0;
            case (state)
                IDLE: begin
                    if (start) begin
                        px        <= pos_x;
                        py        <= pos_y;
                        frame_cnt <= 8'd0;
                        busy      <= 1'b1;
                        state     <= SHOW3;
                    end
                end
                SHOW3, SHOW2, SHOW1: begin
                    if (frame_tick) begin
                        if (last_frame) begin
                            frame_cnt <= 8'd0;
                            if (state == SHOW3) begin
                                state <= SHOW2;
                            end else if (state == SHOW2) begin
                                state <= SHOW1;
                            end else begin
                                state <= FIN;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_countdown_sprite_ctrl.sv
// Bench for countdown_sprite_ctrl: frame-count model checked every cycle plus hand-computed directed checks.
module tb_countdown_sprite_ctrl;
    localparam int FPD = 2;
    localparam int DIM = 32;
`ifdef SPRITE_SCALE2X_EN
    localparam int SC       = 2;
    localparam int EXP_FAR  = 363;
    localparam int EXP_ORG  = 1023;
`else
    localparam int SC       = 1;
    localparam int EXP_FAR  = 759;
    localparam int EXP_ORG  = 0;
`endif

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_clk = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic [9:0]  pos_x = '0;
    logic [9:0]  pos_y = '0;
    logic [18:0] read_address;
    logic        sprite_on;
    logic [1:0]  digit_sel;
    logic        busy;
    logic        done;

    countdown_sprite_ctrl #(.FRAMES_PER_DIGIT(FPD), .SPRITE_DIM(DIM)) dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start(start),
        .DrawX(DrawX), .DrawY(DrawY), .pos_x(pos_x), .pos_y(pos_y),
        .read_address(read_address), .sprite_on(sprite_on), .digit_sel(digit_sel),
        .busy(busy), .done(done)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: countdown is "frames elapsed since start"; digit = 3 - elapsed/FPD
    bit m_busy, m_fin, m_on, m_fq, m_tick;
    int m_el, m_px, m_py, m_dig, m_cur;

    function automatic bit mdl_in_box(int x, int y, int px, int py);
        return (x >= px) && (x < px + DIM * SC) && (y >= py) && (y < py + DIM * SC);
    endfunction

    function automatic int mdl_addr(int x, int y, int px, int py);
        if (!mdl_in_box(x, y, px, py)) return 0;
        return ((y - py) / SC) * DIM + (x - px) / SC;
    endfunction

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_busy = 0; m_fin = 0; m_on = 0; m_fq = 0;
            m_el = 0; m_px = 0; m_py = 0; m_dig = 0;
        end else begin
            m_tick = frame_clk && !m_fq;
            m_fq   = frame_clk;
            m_cur  = m_busy ? 3 - m_el / FPD : 0;
            m_on   = m_busy && mdl_in_box(int'(DrawX), int'(DrawY), m_px, m_py);
            m_dig  = m_on ? m_cur : 0;
            if (m_fin) begin
                m_fin = 0;
            end else if (m_busy) begin
                if (m_tick) begin
                    m_el++;
                    if (m_el == 3 * FPD) begin
                        m_busy = 0;
                        m_fin  = 1;
                    end
                end
            end else if (start) begin
                m_px = int'(pos_x); m_py = int'(pos_y);
                m_el = 0; m_busy = 1;
            end
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            chk("mdl_busy", busy, m_busy);
            chk("mdl_done", done, m_fin);
            chk("mdl_sprite_on", sprite_on, m_on);
            chk("mdl_digit_sel", digit_sel, m_dig);
            chk("mdl_read_address", read_address,
                mdl_addr(int'(DrawX), int'(DrawY), m_px, m_py));
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic frame_pulse();
        frame_clk = 1'b1; step();
        frame_clk = 1'b0; step();
    endtask

    int exp_dig[6] = '{3, 3, 2, 2, 1, 1};

    initial begin
        repeat (2) step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sprite_on", sprite_on, 0);
        chk("rst_digit_sel", digit_sel, 0);
        chk("rst_read_address", read_address, 0);
        Reset = 1'b0;
        chk_en = 1'b1;

        // First countdown at (100,50)
        pos_x = 10'd100; pos_y = 10'd50; DrawX = 10'd105; DrawY = 10'd52;
        start = 1'b1; step(); start = 1'b0;
        chk("busy_after_start", busy, 1);
`ifndef SPRITE_SCALE2X_EN
        chk("addr_105_52", read_address, 69);
`endif
        step();
        chk("on_105_52", sprite_on, 1);
        chk("dig_105_52", digit_sel, 3);
`ifndef SPRITE_SCALE2X_EN
        DrawX = 10'd131; DrawY = 10'd81; #1;
        chk("addr_corner", read_address, 1023);
        step();
        chk("on_corner", sprite_on, 1);
        DrawX = 10'd132; #1;
        chk("addr_right_out", read_address, 0);
        step();
        chk("on_right_out", sprite_on, 0);
        DrawX = 10'd99; #1;
        chk("addr_left_out", read_address, 0);
        step();
        chk("on_left_out", sprite_on, 0);
`endif
        DrawX = 10'd105; DrawY = 10'd52;
        step();

        for (int k = 0; k < 6; k++) begin
            chk("digit_seq", digit_sel, exp_dig[k]);
            chk("busy_seq", busy, 1);
            if (k == 2) begin
                pos_x = 10'd0; pos_y = 10'd0;
                start = 1'b1; step(); start = 1'b0; step();
                chk("ign_start_busy", busy, 1);
                chk("ign_start_digit", digit_sel, 2);
`ifndef SPRITE_SCALE2X_EN
                chk("ign_start_addr", read_address, 69);
`endif
            end
            if (k < 5) frame_pulse();
        end
        frame_clk = 1'b1; step();
        chk("done_pulse", done, 1);
        chk("busy_at_fin", busy, 0);
        frame_clk = 1'b0; step();
        chk("done_cleared", done, 0);
        chk("busy_after_fin", busy, 0);
        chk("digit_after_fin", digit_sel, 0);

        // Second countdown near the 1023 edge
        pos_x = 10'd1000; pos_y = 10'd1000;
        start = 1'b1; step(); start = 1'b0;
        DrawX = 10'd1023; DrawY = 10'd1023; #1;
        chk("addr_edge", read_address, EXP_FAR);
        step();
        chk("on_edge", sprite_on, 1);
        DrawX = 10'd3; #1;
        chk("addr_nowrap", read_address, 0);
        step();
        chk("on_nowrap", sprite_on, 0);

        // Reset in the middle of SHOW2
        DrawX = 10'd1023;
        frame_pulse(); frame_pulse();
        chk("dig_pre_reset", digit_sel, 2);
        Reset = 1'b1; #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_digit", digit_sel, 0);
        chk("async_rst_on", sprite_on, 0);
        step();
        Reset = 1'b0;
        frame_pulse();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_digit", digit_sel, 0);
        chk("post_rst_done", done, 0);

        // Origin sprite: bottom-right pixel only exists in the doubled box
        pos_x = 10'd0; pos_y = 10'd0;
        start = 1'b1; step(); start = 1'b0;
        DrawX = 10'd63; DrawY = 10'd63; #1;
        chk("addr_origin_63", read_address, EXP_ORG);
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
